hazard_forward_unit: RTL

- Producer side of the EX-stage forwarding interface.
- Tracks the destination registers of in-flight instructions in shadow copies of the EX and MEM slots.
- Computes the alumux1/alumux2 forward selects and an rs2 store-data forward select for each instruction while it is in ID, and registers them so they arrive aligned with that instruction in EX.
- Generates the load-use stall/bubble, applies branch flushes, and freezes on data-memory busy.

---
 rtl/hazard_forward_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding-select producer for the EX stage: shadows the EX/MEM destination
// registers, computes next-EX forward selects in ID, and handles load-use, flush and freeze.
module hazard_forward_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_alu1_rs1,
    input  logic             id_alu2_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_busy,
    output logic [1:0]       alumux1_fw,
    output logic [1:0]       alumux2_fw,
    output logic [1:0]       rs2data_fw,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             freeze,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FW_IDEX  = 2'd0;
    localparam logic [1:0] FW_EXMEM = 2'd1;
    localparam logic [1:0] FW_MEMWB = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             is_load;
    } slot_t;

    typedef enum logic {
        RUN,
        LU
    } state_t;

    state_t state_q;
    state_t state_d;
    slot_t  ex_q;
    slot_t  mem_q;
    slot_t  id_slot;
    logic   rs2_used;
    logic   lu_det;
    logic   stall;
    logic   kill;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic [1:0] seld;

    function automatic logic hit(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid & s.regwrite & (s.rd == r) & (r != '0);
    endfunction

    // EX slot is the younger producer, so it wins over MEM
    function automatic logic [1:0] fw_sel(input slot_t ex, input slot_t mem,
                                          input logic [REG_W-1:0] r, input logic en);
        logic [1:0] sel;
        sel = FW_IDEX;
        if (en) begin
            if (hit(ex, r)) begin
                sel = FW_EXMEM;
            end else if (hit(mem, r)) begin
                sel = FW_MEMWB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        rs2_used = id_alu2_rs2 | id_uses_rs2;
        sel1     = fw_sel(ex_q, mem_q, id_rs1, id_alu1_rs1);
        sel2     = fw_sel(ex_q, mem_q, id_rs2, id_alu2_rs2);
        seld     = fw_sel(ex_q, mem_q, id_rs2, id_uses_rs2);
        id_slot  = id_valid ? slot_t'{1'b1, id_rd, id_regwrite, id_is_load} : '0;
    end

    // Next-state and stall outputs; flush and freeze both suppress a load-use stall
    always_comb begin
        state_d     = state_q;
        lu_det      = 1'b0;
        stall       = 1'b0;
        freeze      = mem_busy;
        case (state_q)
            RUN: begin
                lu_det = id_valid & ex_q.is_load &
                         ((hit(ex_q, id_rs1) & id_alu1_rs1) | (hit(ex_q, id_rs2) & rs2_used));
                if (lu_det & ~flush & ~mem_busy) begin
                    stall   = 1'b1;
                    state_d = LU;
                end
            end
            LU: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        stall_ifid  = stall;
        bubble_idex = stall;
        kill        = stall | flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            ex_q         <= '0;
            mem_q        <= '0;
            alumux1_fw   <= FW_IDEX;
            alumux2_fw   <= FW_IDEX;
            rs2data_fw   <= FW_IDEX;
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
        end else if (!mem_busy) begin
            state_q      <= state_d;
            mem_q        <= ex_q;
            ex_q         <= kill ? slot_t'('0) : id_slot;
            alumux1_fw   <= kill ? FW_IDEX : sel1;
            alumux2_fw   <= kill ? FW_IDEX : sel2;
            rs2data_fw   <= kill ? FW_IDEX : seld;
            lu_stall_cnt <= lu_stall_cnt + CNT_W'(stall);
            flush_cnt    <= flush_cnt + CNT_W'(flush);
        end
    end

endmodule
